// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, slot record, XZR.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    localparam logic [4:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rd_used;
        logic       is_load;
    } hz_slot_t;

    // Youngest producer wins: the EX slot outranks the MEM slot.
    function automatic fwd_sel_t fwd_pick(input logic hit_ex, input logic hit_mem);
        if (hit_ex)       return FWD_MEM;
        else if (hit_mem) return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side request and hazard/forwarding response bundle.
interface hazard_unit_if;
    import cpu_pkg::*;

    logic       id_valid;
    logic [4:0] id_rn_addr, id_rm_addr, id_rd_addr;
    logic       id_rn_used, id_rm_used, id_rd_used;
    logic       id_is_load;
    logic       flush;
    logic       stall;
    fwd_sel_t   ex_fwd_a, ex_fwd_b;
    logic       wb_we;
    logic [4:0] wb_rd_addr;

    modport master (
        output id_valid, id_rn_addr, id_rm_addr, id_rd_addr,
               id_rn_used, id_rm_used, id_rd_used, id_is_load, flush,
        input  stall, ex_fwd_a, ex_fwd_b, wb_we, wb_rd_addr
    );

    modport slave (
        input  id_valid, id_rn_addr, id_rm_addr, id_rd_addr,
               id_rn_used, id_rm_used, id_rd_used, id_is_load, flush,
        output stall, ex_fwd_a, ex_fwd_b, wb_we, wb_rd_addr
    );

endinterface

// File: rtl/hazard_unit_src_match.sv
// One source operand against one in-flight producer slot.
module src_match
    import cpu_pkg::*;
(
    input  logic [4:0] src_addr,
    input  logic       src_used,
    input  logic       slot_valid,
    input  logic [4:0] slot_rd,
    input  logic       slot_rd_used,
    output logic       hit
);

    // src_used is the first term so an X address behind used=0 resolves to 0.
    assign hit = src_used && slot_valid && slot_rd_used &&
                 (src_addr == slot_rd) && (src_addr != XZR_ADDR);

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall detection, EX/MEM forwarding selects and WB write-enable tracking.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    localparam int NUM_SRC  = 2;
    localparam int NUM_SLOT = 2;

    hz_slot_t ex_q, mem_q, wb_q, id_slot;
    fwd_sel_t fwd_a_q, fwd_b_q;

    logic [NUM_SRC-1:0][4:0]          src_addr;
    logic [NUM_SRC-1:0]               src_used;
    logic [NUM_SRC-1:0][NUM_SLOT-1:0] hit;
    hz_slot_t [NUM_SLOT-1:0]          cmp_slot;

    assign src_addr = {hz.id_rm_addr, hz.id_rn_addr};
    assign src_used = {hz.id_rm_used, hz.id_rn_used};
    assign cmp_slot = {mem_q, ex_q};

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            for (genvar k = 0; k < NUM_SLOT; k++) begin : g_slot
                src_match u_match (
                    .src_addr     (src_addr[s]),
                    .src_used     (src_used[s]),
                    .slot_valid   (cmp_slot[k].valid),
                    .slot_rd      (cmp_slot[k].rd),
                    .slot_rd_used (cmp_slot[k].rd_used),
                    .hit          (hit[s][k])
                );
            end
        end
    endgenerate

    logic load_use, stall_c, bubble;

    assign load_use = ex_q.is_load && (hit[0][0] || hit[1][0]);
    assign stall_c  = !reset && hz.id_valid && !hz.flush && load_use;
    assign bubble   = !hz.id_valid || hz.flush || stall_c;

    // rd is zeroed when unused so an X destination never reaches wb_rd_addr.
    always_comb begin
        id_slot         = '0;
        id_slot.valid   = !bubble;
        id_slot.rd_used = !bubble && hz.id_rd_used;
        id_slot.rd      = id_slot.rd_used ? hz.id_rd_addr : 5'd0;
        id_slot.is_load = !bubble && hz.id_is_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            ex_q    <= id_slot;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= bubble ? FWD_RF : fwd_pick(hit[0][0], hit[0][1]);
            fwd_b_q <= bubble ? FWD_RF : fwd_pick(hit[1][0], hit[1][1]);
        end
    end

    logic wb_unused;
    assign wb_unused = wb_q.is_load;

    assign hz.stall      = stall_c;
    assign hz.ex_fwd_a   = fwd_a_q;
    assign hz.ex_fwd_b   = fwd_b_q;
    assign hz.wb_we      = !reset && wb_q.valid && wb_q.rd_used && (wb_q.rd != XZR_ADDR);
    assign hz.wb_rd_addr = reset ? 5'd0 : wb_q.rd;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed checks of hazard_unit against an instruction-history model.
module tb_hazard_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_if hz_if();

    hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if.slave)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rn;
        logic       rnu;
        logic [4:0] rm;
        logic       rmu;
        logic [4:0] rd;
        logic       rdu;
        logic       ld;
    } ins_t;

    // History of instructions that left ID: [0]=EX, [1]=MEM, [2]=WB.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rdu;
        bit       ld;
    } ent_t;

    ent_t     hist[$];
    int       n_tests, n_fail;
    bit       m_stall;
    bit [1:0] m_fa, m_fb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(ent_t e, bit used, bit [4:0] a);
        return used && e.v && e.rdu && (e.rd == a) && (a != 5'd31);
    endfunction

    function automatic bit [1:0] sel(bit used, bit [4:0] a);
        if (writes(hist[0], used, a)) return 2'b01;
        if (writes(hist[1], used, a)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic ins_t mk(bit v, bit [4:0] rn, bit rnu, bit [4:0] rm, bit rmu,
                                bit [4:0] rd, bit rdu, bit ld);
        ins_t i;
        i = '{v, rn, rnu, rm, rmu, rd, rdu, ld};
        return i;
    endfunction

    function automatic bit [4:0] rreg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    function automatic ins_t rnd();
        return mk($urandom_range(0, 99) < 85, rreg(), 1'($urandom), rreg(), 1'($urandom),
                  rreg(), 1'($urandom), $urandom_range(0, 2) == 0);
    endfunction

    task automatic clear_hist();
        ent_t z;
        z = '{0, 0, 0, 0};
        hist = {z, z, z};
    endtask

    // One cycle: drive ID, check the combinational stall, advance the model, check registered outputs.
    task automatic step(input ins_t i, input bit fl, input bit rst, output bit obs_stall);
        ent_t e;
        bit   bub;
        @(negedge clk);
        reset            = rst;
        hz_if.id_valid   = i.v;
        hz_if.id_rn_addr = i.rn;
        hz_if.id_rn_used = i.rnu;
        hz_if.id_rm_addr = i.rm;
        hz_if.id_rm_used = i.rmu;
        hz_if.id_rd_addr = i.rd;
        hz_if.id_rd_used = i.rdu;
        hz_if.id_is_load = i.ld;
        hz_if.flush      = fl;
        #1;
        m_stall = !rst && i.v && !fl && hist[0].ld &&
                  (writes(hist[0], i.rnu, i.rn) || writes(hist[0], i.rmu, i.rm));
        obs_stall = hz_if.stall;
        chk("stall", 32'(hz_if.stall), 32'(m_stall));
        if (rst) begin
            clear_hist();
            m_fa = 0;
            m_fb = 0;
        end else begin
            bub  = !i.v || fl || m_stall;
            m_fa = bub ? 2'b00 : sel(i.rnu, i.rn);
            m_fb = bub ? 2'b00 : sel(i.rmu, i.rm);
            e.v   = !bub;
            e.rdu = !bub && i.rdu;
            e.rd  = e.rdu ? i.rd : 5'd0;
            e.ld  = !bub && i.ld;
            hist.push_front(e);
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        chk("fwd_a", 32'(hz_if.ex_fwd_a), 32'(m_fa));
        chk("fwd_b", 32'(hz_if.ex_fwd_b), 32'(m_fb));
        chk("wb_we", 32'(hz_if.wb_we),
            32'(hist[2].v && hist[2].rdu && hist[2].rd != 5'd31));
        chk("wb_rd", 32'(hz_if.wb_rd_addr), 32'(hist[2].rd));
    endtask

    initial begin
        ins_t nop, cur;
        bit   st;
        n_tests = 0;
        n_fail  = 0;
        clear_hist();
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);

        step(nop, 0, 1, st);
        step(nop, 0, 1, st);
        chk("rst_fwd_a", 32'(hz_if.ex_fwd_a), 0);
        chk("rst_we", 32'(hz_if.wb_we), 0);
        chk("rst_stall", 32'(st), 0);

        // ADD X1,X2,X3 ; ADD X2,X1,X3
        step(mk(1, 2, 1, 3, 1, 1, 1, 0), 0, 0, st);
        step(mk(1, 1, 1, 3, 1, 2, 1, 0), 0, 0, st);
        chk("alu_fwd_a", 32'(hz_if.ex_fwd_a), 32'h1);
        chk("alu_nostall", 32'(st), 0);

        // LDUR X4,[X10] ; SUB X5,X4,X6 (held once by the stall)
        step(mk(1, 10, 1, 0, 0, 4, 1, 1), 0, 0, st);
        step(mk(1, 4, 1, 6, 1, 5, 1, 0), 0, 0, st);
        chk("lu_stall", 32'(st), 1);
        chk("lu_bubble_fwd", 32'(hz_if.ex_fwd_a), 0);
        step(mk(1, 4, 1, 6, 1, 5, 1, 0), 0, 0, st);
        chk("lu_stall_once", 32'(st), 0);
        chk("lu_fwd_a", 32'(hz_if.ex_fwd_a), 32'h2);
        chk("lu_wb_we", 32'(hz_if.wb_we), 1);
        chk("lu_wb_rd", 32'(hz_if.wb_rd_addr), 4);

        // Two X7 writers then a reader on rm: youngest wins.
        step(mk(1, 1, 1, 2, 1, 7, 1, 0), 0, 0, st);
        step(mk(1, 2, 1, 3, 1, 7, 1, 0), 0, 0, st);
        step(mk(1, 0, 1, 7, 1, 8, 1, 0), 0, 0, st);
        chk("youngest_fwd_b", 32'(hz_if.ex_fwd_b), 32'h1);

        // Writer XZR then reader XZR.
        step(mk(1, 1, 1, 2, 1, 31, 1, 0), 0, 0, st);
        step(mk(1, 31, 1, 31, 1, 9, 1, 0), 0, 0, st);
        chk("xzr_fwd_a", 32'(hz_if.ex_fwd_a), 0);
        step(nop, 0, 0, st);
        chk("xzr_we", 32'(hz_if.wb_we), 0);

        // Unused rm carrying X.
        cur = mk(1, 9, 1, 0, 0, 3, 1, 0);
        cur.rm = 'x;
        step(cur, 0, 0, st);
        chk("x_free", 32'($isunknown({hz_if.stall, hz_if.ex_fwd_a, hz_if.ex_fwd_b,
                                      hz_if.wb_we, hz_if.wb_rd_addr})), 0);

        // Load-use with flush in the would-be stall cycle.
        step(mk(1, 10, 1, 0, 0, 4, 1, 1), 0, 0, st);
        step(mk(1, 4, 1, 6, 1, 5, 1, 0), 1, 0, st);
        chk("flush_nostall", 32'(st), 0);
        chk("flush_fwd_a", 32'(hz_if.ex_fwd_a), 0);

        // Reset during a stall.
        step(mk(1, 10, 1, 0, 0, 4, 1, 1), 0, 0, st);
        step(mk(1, 1, 1, 4, 1, 5, 1, 0), 0, 0, st);
        chk("rs_stall_pre", 32'(st), 1);
        step(mk(1, 1, 1, 4, 1, 5, 1, 0), 0, 1, st);
        chk("rs_we", 32'(hz_if.wb_we), 0);
        step(mk(1, 1, 1, 4, 1, 5, 1, 0), 0, 0, st);
        chk("rs_stall_post", 32'(st), 0);

        cur = rnd();
        for (int c = 0; c < 400; c++) begin
            step(cur, $urandom_range(0, 9) == 0, 0, st);
            if (!m_stall) cur = rnd();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
